// File: rtl/jtkunio_objdma_pkg.sv
// Shared types and default constants for the object-RAM DMA engine.
package jtkunio_objdma_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam int          ADDR_W_DEF   = 12;
  localparam int          CNT_W_DEF    = 8;
  localparam int          LEN_DEF      = 256;
  localparam logic [11:0] SRC_BASE_DEF = 12'h800;

endpackage

// File: rtl/jtkunio_objdma_if.sv
// CPU-bus handshake, source RAM read port and object-buffer write port.
interface jtkunio_objdma_if #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 8
);
  logic              busrq;
  logic              busak_n;
  logic [ADDR_W-1:0] dma_addr;
  logic [7:0]        ram_dout;
  logic [CNT_W-1:0]  obj_addr;
  logic [7:0]        obj_din;
  logic              obj_we;

  modport master (
    output busrq, dma_addr, obj_addr, obj_din, obj_we,
    input  busak_n, ram_dout
  );

  modport slave (
    input  busrq, dma_addr, obj_addr, obj_din, obj_we,
    output busak_n, ram_dout
  );
endinterface

// File: rtl/jtkunio_objdma_edge.sv
// Rising-edge detector on a level input, sampled only on clock-enable cycles.
module jtkunio_objdma_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic cen,
  input  logic sig_i,
  output logic rise_o
);
  logic prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else if (cen) begin
      prev_q <= sig_i;
    end
  end

  assign rise_o = cen & sig_i & ~prev_q;
endmodule

// File: rtl/jtkunio_objdma.sv
// Object-RAM DMA: grabs the CPU bus and copies LEN sprite bytes into the object buffer.
// Optional JTKUNIO_OBJDMA_VBWAIT_EN holds new requests until vertical blank.
module jtkunio_objdma
  import jtkunio_objdma_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                CNT_W    = CNT_W_DEF,
  parameter int                LEN      = LEN_DEF,
  parameter logic [ADDR_W-1:0] SRC_BASE = ADDR_W'(SRC_BASE_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             LVBL,
  input  logic             dma_go,
  jtkunio_objdma_if.master bus,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W:0] LAST = (CNT_W+1)'(LEN - 1);

  state_e         state_q, state_d;
  logic [CNT_W:0] rd_q, rd_d;     // index of byte whose address is on dma_addr
  logic [CNT_W:0] wr_q, wr_d;     // index of next byte to be written
  logic           have_q, have_d; // ram_dout currently holds byte wr_q
  logic           pend_q, pend_d;
  logic           go_rise;
  logic           vb_ok;
  logic           wr_c;

  jtkunio_objdma_edge u_go_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .cen    (cen),
    .sig_i  (dma_go),
    .rise_o (go_rise)
  );

`ifdef JTKUNIO_OBJDMA_VBWAIT_EN
  assign vb_ok = ~LVBL;
`else
  logic unused_lvbl;
  assign unused_lvbl = LVBL;
  assign vb_ok       = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      have_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else if (cen) begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      have_q  <= have_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    have_d  = have_q;
    pend_d  = pend_q | go_rise;
    wr_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if ((pend_q | go_rise) && vb_ok) begin
          state_d = REQ;
          pend_d  = 1'b0;
          rd_d    = '0;
          wr_d    = '0;
          have_d  = 1'b0;
        end
      end
      REQ: begin
        if (!bus.busak_n) begin
          state_d = XFER;
        end
      end
      XFER: begin
        if (bus.busak_n) begin
          // CPU took the bus back: drop this cycle's write and re-issue
          // the first unwritten byte once the bus is granted again.
          state_d = REQ;
          rd_d    = wr_q;
          have_d  = 1'b0;
        end else begin
          rd_d   = rd_q + 1'b1;
          have_d = 1'b1;
          if (have_q) begin
            wr_c = 1'b1;
            wr_d = wr_q + 1'b1;
            if (wr_q == LAST) begin
              state_d = RELEASE;
              rd_d    = '0;
              wr_d    = '0;
              have_d  = 1'b0;
            end
          end
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busrq    = (state_q == REQ) || (state_q == XFER);
  assign busy         = bus.busrq;
  assign bus.dma_addr = SRC_BASE + ADDR_W'(rd_q);
  assign bus.obj_addr = wr_q[CNT_W-1:0];
  assign bus.obj_din  = bus.ram_dout;
  // Strobes are qualified by rst_n so a reset edge never writes or completes.
  assign bus.obj_we   = rst_n & cen & wr_c;
  assign done         = rst_n & cen & (state_q == RELEASE);

endmodule

// File: tb/tb_jtkunio_objdma.sv
// Directed bench for jtkunio_objdma: default 256-byte instance plus a 4-byte wrapping instance.
module tb_jtkunio_objdma;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cen = 1'b0;
`ifdef JTKUNIO_OBJDMA_VBWAIT_EN
  logic LVBL = 1'b0;
`else
  logic LVBL = 1'b1;
`endif
  logic dma_go = 1'b0, dma_go2 = 1'b0;
  logic busak_n = 1'b1, busak2_n = 1'b1;
  logic busy, done, busy2, done2;
  logic [7:0] ram_q = 8'h00, ram2_q = 8'h00;

  jtkunio_objdma_if #(.ADDR_W(12), .CNT_W(8)) bus ();
  jtkunio_objdma_if #(.ADDR_W(12), .CNT_W(8)) bus2 ();

  assign bus.busak_n  = busak_n;
  assign bus.ram_dout = ram_q;
  assign bus2.busak_n  = busak2_n;
  assign bus2.ram_dout = ram2_q;

  jtkunio_objdma u_dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .LVBL(LVBL), .dma_go(dma_go),
    .bus(bus), .busy(busy), .done(done)
  );

  jtkunio_objdma #(.ADDR_W(12), .CNT_W(8), .LEN(4), .SRC_BASE(12'hFFE)) u_small (
    .clk(clk), .rst_n(rst_n), .cen(cen), .LVBL(LVBL), .dma_go(dma_go2),
    .bus(bus2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  int cen_div = 0;
  always @(negedge clk) begin
    cen_div = (cen_div + 1) % 8;
    cen = (cen_div == 0);
  end

  // RAM model: byte at address a is a[7:0]^0x5A, one cen-cycle read latency.
  logic [7:0]  obuf [256];
  logic [11:0] osrc [256];
  int          oep  [256];
  logic [7:0]  obuf2 [256];
  logic [11:0] osrc2 [256];
  logic [11:0] last_q = 12'h0, last2_q = 12'h0;
  int epoch = 0;
  int we_cnt = 0, done_cnt = 0, we2_cnt = 0;

  always @(posedge clk) begin
    if (cen) begin
      ram_q   <= bus.dma_addr[7:0] ^ 8'h5A;
      ram2_q  <= bus2.dma_addr[7:0] ^ 8'h5A;
      last_q  <= bus.dma_addr;
      last2_q <= bus2.dma_addr;
    end
    if (bus.obj_we) begin
      obuf[bus.obj_addr] <= bus.obj_din;
      osrc[bus.obj_addr] <= last_q;
      oep[bus.obj_addr]  <= epoch;
      we_cnt <= we_cnt + 1;
    end
    if (bus2.obj_we) begin
      obuf2[bus2.obj_addr] <= bus2.obj_din;
      osrc2[bus2.obj_addr] <= last2_q;
      we2_cnt <= we2_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  int n_vec = 0, n_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cen_tick();
    do @(posedge clk); while (!cen);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cen_tick();
  endtask

  task automatic run_to_release(output int n);
    n = 0;
    while (bus.busrq && n < 1000) begin
      cen_tick();
      n++;
    end
  endtask

  task automatic wait_writes(input int base, input int target);
    int k;
    k = 0;
    while ((we_cnt - base) < target && k < 1000) begin
      cen_tick();
      k++;
    end
    check_eq("wait_bytes", 32'(we_cnt - base), 32'(target));
  endtask

  task automatic check_buffer(input string tag);
    int errs;
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      if (oep[i] != epoch || obuf[i] !== (8'(i) ^ 8'h5A) || osrc[i] !== (12'h800 + 12'(i)))
        errs++;
    end
    check_eq(tag, 32'(errs), 32'd0);
  endtask

  int n, we0, done0;

  initial begin
    for (int i = 0; i < 256; i++) oep[i] = 0;
    // Reset state
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busrq", 32'(bus.busrq), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_dma_addr", 32'(bus.dma_addr), 32'h800);
    check_eq("rst_obj_addr", 32'(bus.obj_addr), 32'd0);
    check_eq("rst_small_addr", 32'(bus2.dma_addr), 32'hFFE);
    rst_n = 1'b1;
    ticks(2);

    // Test 1: plain full transfer
    epoch = 1; we0 = we_cnt; done0 = done_cnt;
    dma_go = 1'b1;
    cen_tick();
    check_eq("t1_busrq_req", 32'(bus.busrq), 32'd1);
    check_eq("t1_busy_req", 32'(busy), 32'd1);
    ticks(2);
    busak_n = 1'b0;
    run_to_release(n);
    check_eq("t1_cycles", 32'(n), 32'd258);
    busak_n = 1'b1;
    dma_go  = 1'b0;
    cen_tick();
    check_eq("t1_writes", 32'(we_cnt - we0), 32'd256);
    check_eq("t1_done", 32'(done_cnt - done0), 32'd1);
    check_eq("t1_busy_end", 32'(busy), 32'd0);
    check_buffer("t1_buffer");
    $display("test1 full transfer: %0d writes", we_cnt - we0);

    // Test 2: bus taken back at byte 100
    epoch = 2; we0 = we_cnt; done0 = done_cnt;
    dma_go = 1'b1;
    cen_tick();
    busak_n = 1'b0;
    wait_writes(we0, 100);
    busak_n = 1'b1;
    cen_tick();
    check_eq("t2_busrq_held", 32'(bus.busrq), 32'd1);
    check_eq("t2_resume_addr", 32'(bus.dma_addr), 32'h864);
    check_eq("t2_suppressed", 32'(we_cnt - we0), 32'd100);
    ticks(4);
    check_eq("t2_hold_addr", 32'(bus.dma_addr), 32'h864);
    busak_n = 1'b0;
    run_to_release(n);
    check_eq("t2_cycles", 32'(n), 32'd158);
    busak_n = 1'b1;
    dma_go  = 1'b0;
    cen_tick();
    check_eq("t2_writes", 32'(we_cnt - we0), 32'd256);
    check_eq("t2_done", 32'(done_cnt - done0), 32'd1);
    check_buffer("t2_buffer");
    $display("test2 interrupted transfer: %0d writes", we_cnt - we0);

    // Test 3: one pending request, a second one dropped
    epoch = 3; we0 = we_cnt; done0 = done_cnt;
    dma_go = 1'b1;
    cen_tick();
    busak_n = 1'b0;
    dma_go  = 1'b0;
    cen_tick();
    wait_writes(we0, 50);
    dma_go = 1'b1; cen_tick();
    dma_go = 1'b0; cen_tick();
    dma_go = 1'b1; cen_tick();
    dma_go = 1'b0;
    n = 0;
    while ((done_cnt - done0) < 2 && n < 2000) begin
      cen_tick();
      n++;
    end
    ticks(20);
    check_eq("t3_done", 32'(done_cnt - done0), 32'd2);
    check_eq("t3_writes", 32'(we_cnt - we0), 32'd512);
    check_eq("t3_busy_end", 32'(busy), 32'd0);
    check_eq("t3_busrq_end", 32'(bus.busrq), 32'd0);
    check_buffer("t3_buffer");
    busak_n = 1'b1;
    $display("test3 pending request: %0d done pulses", done_cnt - done0);

    // Test 4: reset in the middle of a transfer
    epoch = 4; we0 = we_cnt;
    dma_go = 1'b1;
    cen_tick();
    busak_n = 1'b0;
    dma_go  = 1'b0;
    wait_writes(we0, 30);
    rst_n = 1'b0;
    cen_tick();
    check_eq("t4_rst_busrq", 32'(bus.busrq), 32'd0);
    check_eq("t4_rst_writes", 32'(we_cnt - we0), 32'd30);
    check_eq("t4_rst_addr", 32'(bus.dma_addr), 32'h800);
    rst_n   = 1'b1;
    busak_n = 1'b1;
    cen_tick();
    epoch = 5; we0 = we_cnt; done0 = done_cnt;
    dma_go = 1'b1;
    cen_tick();
    check_eq("t4_restart_addr", 32'(bus.dma_addr), 32'h800);
    busak_n = 1'b0;
    run_to_release(n);
    busak_n = 1'b1;
    dma_go  = 1'b0;
    cen_tick();
    check_eq("t4_writes", 32'(we_cnt - we0), 32'd256);
    check_eq("t4_done", 32'(done_cnt - done0), 32'd1);
    check_buffer("t4_buffer");
    $display("test4 reset mid-transfer and restart: %0d writes", we_cnt - we0);

    // Test 5: LEN=4 starting at 0xFFE wraps the source address
    we0 = we2_cnt;
    dma_go2 = 1'b1;
    cen_tick();
    busak2_n = 1'b0;
    n = 0;
    while (bus2.busrq && n < 100) begin
      cen_tick();
      n++;
    end
    check_eq("t5_cycles", 32'(n), 32'd6);
    check_eq("t5_writes", 32'(we2_cnt - we0), 32'd4);
    check_eq("t5_src0", 32'(osrc2[0]), 32'hFFE);
    check_eq("t5_src1", 32'(osrc2[1]), 32'hFFF);
    check_eq("t5_src2", 32'(osrc2[2]), 32'h000);
    check_eq("t5_src3", 32'(osrc2[3]), 32'h001);
    check_eq("t5_dat0", 32'(obuf2[0]), 32'hA4);
    check_eq("t5_dat3", 32'(obuf2[3]), 32'h5B);
    busak2_n = 1'b1;
    dma_go2  = 1'b0;
    cen_tick();
    $display("test5 wrapping transfer: %0d writes", we2_cnt - we0);

    // Test 6: request timing against LVBL
    we0 = we_cnt;
`ifdef JTKUNIO_OBJDMA_VBWAIT_EN
    LVBL   = 1'b1;
    dma_go = 1'b1;
    ticks(3);
    check_eq("t6_held_busrq", 32'(bus.busrq), 32'd0);
    LVBL = 1'b0;
    cen_tick();
    check_eq("t6_vb_busrq", 32'(bus.busrq), 32'd1);
`else
    LVBL   = 1'b1;
    dma_go = 1'b1;
    cen_tick();
    check_eq("t6_busrq", 32'(bus.busrq), 32'd1);
`endif
    busak_n = 1'b0;
    run_to_release(n);
    busak_n = 1'b1;
    dma_go  = 1'b0;
    cen_tick();
    check_eq("t6_writes", 32'(we_cnt - we0), 32'd256);
    $display("test6 LVBL gating: %0d writes", we_cnt - we0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
